// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared word/address types, RAM status encoding and the
// memory-arbiter state type used across the core.
package cpu_types_pkg;

  localparam int unsigned WORD_BITS = 32;
  localparam int unsigned ADDR_BITS = 32;

  typedef logic [WORD_BITS-1:0] word_t;
  typedef logic [ADDR_BITS-1:0] addr_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2,
    COOL   = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the fetch, data and RAM sides of mem_arbiter;
// modport arb is the arbiter's view, modport tb the surrounding system's.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input logic CLK
);
  import cpu_types_pkg::*;

  logic              nRST;
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic              iwait;
  logic [DATA_W-1:0] iload;
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic              dwait;
  logic [DATA_W-1:0] dload;
  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [DATA_W-1:0] ramstore;
  logic [DATA_W-1:0] ramload;
  ramstate_t         ramstate;

  modport arb (
    input  CLK, nRST, iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport tb (
    input  CLK, iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore,
    output nRST, iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate
  );

endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single RAM port between fetch and data requesters, data wins ties.
// Define ARB_STARVE_GUARD_EN to compile in the streak counter that bounds fetch starvation.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  ramstate_t         ramstate
);

  arb_state_t state, next_state;
  logic       dreq;
  logic       ram_done;
  logic       starve;

  always_comb begin
    dreq     = dREN | dWEN;
    ram_done = (ramstate == ACCESS);
  end

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned STREAK_W = $clog2(STARVE_MAX + 1);
  localparam logic [STREAK_W-1:0] STREAK_LIM = STREAK_W'(STARVE_MAX);

  logic [STREAK_W-1:0] streak, streak_next;

  always_comb starve = iREN & dreq & (streak == STREAK_LIM);

  // Only IDLE decisions move the streak; grants held across BUSY/ERROR do not.
  always_comb begin
    streak_next = streak;
    if (state == IDLE) begin
      if (dreq && !starve) begin
        if (!iREN) begin
          streak_next = '0;
        end else if (streak != STREAK_LIM) begin
          streak_next = streak + STREAK_W'(1);
        end
      end else if (iREN) begin
        streak_next = '0;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      streak <= '0;
    end else begin
      streak <= streak_next;
    end
  end
`else
  always_comb starve = 1'b0;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // RAM side is a pure function of state and live requests, so a withdrawn
  // request or an asserted reset drops the enables in the same cycle.
  always_comb begin
    next_state = state;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    iload      = '0;
    dload      = '0;
    unique case (state)
      IDLE: begin
        if (dreq && !starve) begin
          next_state = DGRANT;
        end else if (iREN) begin
          next_state = IGRANT;
        end
      end
      IGRANT: begin
        ramaddr = iaddr;
        if (!iREN) begin
          next_state = IDLE;
        end else begin
          ramREN = 1'b1;
          if (ram_done) begin
            iload      = ramload;
            next_state = COOL;
          end
        end
      end
      DGRANT: begin
        ramREN   = dREN;
        ramWEN   = dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        if (!dreq) begin
          next_state = IDLE;
        end else if (ram_done) begin
          dload      = ramload;
          next_state = COOL;
        end
      end
      COOL: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_comb begin
    iwait = iREN & ~((state == IGRANT) & ram_done);
    dwait = dreq & ~((state == DGRANT) & ram_done);
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized requesters and RAM around mem_arbiter, scoreboard
// queues per requester, a transaction-level arbitration model and directed corner cases.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int unsigned SMAX  = 4;
  localparam int          LIMIT = 300;

  logic        CLK;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore;
  logic        iwait, dwait;
  logic [31:0] iload, dload;
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore, ramload;
  ramstate_t   ramstate;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SMAX)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t        iq[$];
  exp_t        dq[$];
  logic [31:0] ram_d [16];
  logic [31:0] ref_d [16];

  int          n_cmp = 0;
  int          n_fail = 0;
  int unsigned ram_mode = 0;
  int unsigned run = 0;
  bit          i_active = 0, d_active = 0, i_done = 0, d_done = 0;
  bit          i_granted = 0, d_granted = 0;
  bit          prev_en = 0, prev_i = 0, prev_d = 0;
  int          i_age = 0, d_age = 0;

  function automatic logic [31:0] memval(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hA5A50F0F;
  endfunction

  function automatic void check1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // RAM: random status every cycle, read data from its own storage.
  always @(negedge CLK) begin : ram_model
    int unsigned r;
    #1;
    if (ram_mode == 0) begin
      r = $urandom_range(0, 9);
      if (r < 5)      ramstate = ACCESS;
      else if (r < 8) ramstate = BUSY;
      else            ramstate = ERROR;
    end else if (ram_mode == 1) begin
      ramstate = BUSY;
    end else if (ram_mode == 2) begin
      ramstate = ACCESS;
    end
    if (ram_mode != 4)
      ramload = ramREN ? (ramaddr[12] ? ram_d[ramaddr[5:2]] : memval(ramaddr)) : $urandom;
  end

  always @(posedge CLK) begin
    if (nRST && ramWEN && ramstate == ACCESS) ram_d[ramaddr[5:2]] <= ramstore;
  end

  // Monitor: completions against scoreboards, grant order against the priority rules.
  always @(negedge CLK) begin : monitor
    exp_t e;
    logic icomp, dcomp, en, owner_d, exp_d;
    #3;
    if (nRST) begin
      icomp = iREN & ~iwait;
      dcomp = (dREN | dWEN) & ~dwait;
      en    = ramREN | ramWEN;
      check1("rw_exclusive", ramREN & ramWEN, 1'b0);
      check1("ren_without_req", ramREN & ~iREN & ~dREN, 1'b0);
      check1("wen_without_dwen", ramWEN & ~dWEN, 1'b0);
      check1("dual_complete", icomp & dcomp, 1'b0);
      check1("iwait_no_req", iwait & ~iREN, 1'b0);
      check1("dwait_no_req", dwait & ~(dREN | dWEN), 1'b0);
      if (!icomp) check32("iload_zero", iload, 32'h0);
      if (!dcomp) check32("dload_zero", dload, 32'h0);
      if (icomp) begin
        check32("i_pending_count", 32'(iq.size()), 32'd1);
        if (iq.size() != 0) begin
          e = iq.pop_front();
          check32("iload", iload, e.data);
          check32("i_ramaddr", ramaddr, e.addr);
          check1("i_ramren", ramREN, 1'b1);
        end
        i_done = 1;
      end
      if (dcomp) begin
        check32("d_pending_count", 32'(dq.size()), 32'd1);
        if (dq.size() != 0) begin
          e = dq.pop_front();
          check32("d_ramaddr", ramaddr, e.addr);
          if (e.wr) begin
            check1("d_ramwen", ramWEN, 1'b1);
            check32("d_ramstore", ramstore, e.data);
            ref_d[e.addr[5:2]] = e.data;
          end else begin
            check1("d_ramren", ramREN, 1'b1);
            check32("dload", dload, e.data);
          end
        end
        d_done = 1;
      end
      if (en && !prev_en) begin
        owner_d = ramaddr[12];
        check1("grant_needs_request", prev_i | prev_d, 1'b1);
        if (prev_i && prev_d) begin
`ifdef ARB_STARVE_GUARD_EN
          exp_d = (run != SMAX);
`else
          exp_d = 1'b1;
`endif
        end else begin
          exp_d = prev_d;
        end
        check1("grant_owner", owner_d, exp_d);
        if (owner_d) run = prev_i ? ((run < SMAX) ? run + 1 : run) : 0;
        else         run = 0;
      end
      prev_en   = en;
      prev_i    = iREN;
      prev_d    = dREN | dWEN;
      i_granted = ramREN & ~ramaddr[12] & ~icomp;
      d_granted = en & ramaddr[12] & ~dcomp;
    end
  end

  task automatic issue_i();
    int unsigned k = $urandom_range(0, 15);
    iaddr = 32'h40 + (k << 2);
    iREN  = 1'b1;
    iq.push_back('{1'b0, iaddr, memval(iaddr)});
    i_active = 1;
    i_age    = 0;
  endtask

  task automatic issue_d();
    int unsigned k = $urandom_range(0, 15);
    bit wr = 1'($urandom_range(0, 1));
    daddr = 32'h1000 + (k << 2);
    if (wr) begin
      dstore = $urandom;
      dq.push_back('{1'b1, daddr, dstore});
    end else begin
      dq.push_back('{1'b0, daddr, ref_d[k]});
    end
    dREN = ~wr;
    dWEN = wr;
    d_active = 1;
    d_age    = 0;
  endtask

  // One requester cycle: retire, occasionally withdraw while granted, maybe issue.
  task automatic step(input bit allow, input bit greedy);
    @(negedge CLK);
    if (i_done) begin
      i_done = 0; i_active = 0; iREN = 1'b0;
    end else if (i_active) begin
      i_age++;
      if (i_age > LIMIT) begin
        check32("i_wait_bound", 32'(i_age), 32'(LIMIT));
        iREN = 1'b0; i_active = 0; void'(iq.pop_back());
      end else if (i_granted && $urandom_range(0, 15) == 0) begin
        iREN = 1'b0; i_active = 0; void'(iq.pop_back());
      end
    end
    if (allow && !i_active && (greedy || $urandom_range(0, 2) == 0)) issue_i();
    if (d_done) begin
      d_done = 0; d_active = 0; dREN = 1'b0; dWEN = 1'b0;
    end else if (d_active) begin
      d_age++;
      if (d_age > LIMIT) begin
        check32("d_wait_bound", 32'(d_age), 32'(LIMIT));
        dREN = 1'b0; dWEN = 1'b0; d_active = 0; void'(dq.pop_back());
      end else if (d_granted && $urandom_range(0, 15) == 0) begin
        dREN = 1'b0; dWEN = 1'b0; d_active = 0; void'(dq.pop_back());
      end
    end
    if (allow && !d_active && (greedy || $urandom_range(0, 2) == 0)) issue_d();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    iREN = 0; dREN = 0; dWEN = 0;
    iaddr = 0; daddr = 32'h1000; dstore = 0;
    ramstate = FREE; ramload = 0;
    for (int k = 0; k < 16; k++) begin
      ram_d[k] = memval(32'h1000 + 32'(k << 2));
      ref_d[k] = ram_d[k];
    end
    nRST = 1'b1;
    #1 nRST = 1'b0;
    repeat (2) @(negedge CLK);
    #4;
    check1("rst_ramREN", ramREN, 1'b0);
    check1("rst_ramWEN", ramWEN, 1'b0);
    check32("rst_ramaddr", ramaddr, 32'h0);
    check32("rst_ramstore", ramstore, 32'h0);
    check32("rst_iload", iload, 32'h0);
    check32("rst_dload", dload, 32'h0);
    iREN = 1'b1; dWEN = 1'b1;
    #1;
    check1("rst_iwait_follows_req", iwait, 1'b1);
    check1("rst_dwait_follows_req", dwait, 1'b1);
    check1("rst_ramREN_held", ramREN, 1'b0);
    iREN = 1'b0; dWEN = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;

    for (int c = 0; c < 2600; c++) step(1'b1, (c >= 2000 && c < 2150));
    for (int n = 0; n < 300 && (i_active || d_active); n++) step(1'b0, 1'b0);
    check1("drain_idle", i_active | d_active, 1'b0);
    repeat (3) @(negedge CLK);

    // Single fetch, RAM answers immediately.
    ram_mode = 2;
    @(negedge CLK);
    iaddr = 32'h40; iREN = 1'b1;
    iq.push_back('{1'b0, 32'h40, memval(32'h40)});
    #4 check1("sr_c0_iwait", iwait, 1'b1); check1("sr_c0_ramREN", ramREN, 1'b0);
    @(negedge CLK);
    #4 check1("sr_c1_iwait", iwait, 1'b0); check32("sr_c1_iload", iload, memval(32'h40));
    check32("sr_c1_ramaddr", ramaddr, 32'h40);
    @(negedge CLK);
    #4 check1("sr_c2_ramREN", ramREN, 1'b0); check32("sr_c2_iload", iload, 32'h0);
    @(negedge CLK);
    iREN = 1'b0; i_done = 0;
    repeat (2) @(negedge CLK);

    // Write with three BUSY cycles, then ACCESS.
    ram_mode = 4;
    @(negedge CLK);
    dWEN = 1'b1; daddr = 32'h1100; dstore = 32'h12345678;
    dq.push_back('{1'b1, 32'h1100, 32'h12345678});
    ramstate = BUSY; ramload = 32'hCAFEF00D;
    #4 check1("wr_c0_ramWEN", ramWEN, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge CLK);
      if (c == 4) ramstate = ACCESS; else ramstate = BUSY;
      #4;
      check1("wr_ramWEN", ramWEN, 1'b1);
      check1("wr_dwait", dwait, (c == 4) ? 1'b0 : 1'b1);
      check32("wr_ramstore", ramstore, 32'h12345678);
    end
    @(negedge CLK);
    dWEN = 1'b0; ramstate = BUSY;
    #4 check1("wr_cool_ramWEN", ramWEN, 1'b0);
    d_done = 0;
    repeat (2) @(negedge CLK);

    // Tie: data first (reads back the write above), fetch after COOL.
    ram_mode = 2;
    @(negedge CLK);
    iaddr = 32'h44; iREN = 1'b1; daddr = 32'h1100; dREN = 1'b1;
    iq.push_back('{1'b0, 32'h44, memval(32'h44)});
    dq.push_back('{1'b0, 32'h1100, ref_d[0]});
    @(negedge CLK);
    #4 check32("tie_c1_ramaddr", ramaddr, 32'h1100); check1("tie_c1_iwait", iwait, 1'b1);
    check32("tie_c1_dload", dload, 32'h12345678);
    @(negedge CLK);
    dREN = 1'b0;
    #4 check1("tie_c2_ramREN", ramREN, 1'b0); check1("tie_c2_iwait", iwait, 1'b1);
    @(negedge CLK);
    @(negedge CLK);
    #4 check32("tie_c4_ramaddr", ramaddr, 32'h44); check1("tie_c4_iwait", iwait, 1'b0);
    @(negedge CLK);
    iREN = 1'b0; i_done = 0; d_done = 0;
    repeat (2) @(negedge CLK);

    // Withdrawal during BUSY, then fetch grant, then reset mid-grant.
    ram_mode = 4;
    @(negedge CLK);
    dREN = 1'b1; daddr = 32'h1004; ramstate = BUSY;
    dq.push_back('{1'b0, 32'h1004, ref_d[1]});
    @(negedge CLK);
    #4 check1("wd_c1_ramREN", ramREN, 1'b1);
    @(negedge CLK);
    dREN = 1'b0; void'(dq.pop_back()); ramstate = ACCESS;
    #4 check1("wd_c2_ramREN", ramREN, 1'b0); check32("wd_c2_dload", dload, 32'h0);
    check1("wd_c2_dwait", dwait, 1'b0);
    @(negedge CLK);
    iREN = 1'b1; iaddr = 32'h48; ramstate = BUSY;
    iq.push_back('{1'b0, 32'h48, memval(32'h48)});
    #4 check1("wd_c3_ramREN", ramREN, 1'b0);
    @(negedge CLK);
    #4 check1("wd_c4_ramREN", ramREN, 1'b1); check32("wd_c4_ramaddr", ramaddr, 32'h48);
    nRST = 1'b0;
    #1 check1("rstmid_ramREN", ramREN, 1'b0); check1("rstmid_iwait", iwait, 1'b1);
    check32("rstmid_iload", iload, 32'h0);
    iq.delete(); run = 0;
    @(negedge CLK);
    nRST = 1'b1;
    #4 check1("rstrel_ramREN", ramREN, 1'b0);
    @(negedge CLK);
    #4 check1("rstrel_regrant_ramREN", ramREN, 1'b1); check32("rstrel_ramaddr", ramaddr, 32'h48);
    @(negedge CLK);
    iREN = 1'b0;
    repeat (2) @(negedge CLK);
    check32("iq_empty", 32'(iq.size()), 32'd0);
    check32("dq_empty", 32'(dq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequential arbiter that shares the single RAM port between the instruction-fetch requester and the data-memory requester of the pipelined core. It sits between the cache/fetch side and RAM, and grants one requester at a time. It holds each grant until RAM reports completion, and returns per-requester wait/load signals. Data requests win ties, because a stalled memory stage freezes the whole pipeline; an optional streak counter prevents fetch starvation.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data word width
- STARVE_MAX, 4, max consecutive data grants while fetch is pending (guard build only)

Ports (clock is `CLK`, reset is `nRST`):
- CLK  in  1  single clock, rising-edge
- nRST  in  1  reset; asynchronous, active-low
- iREN  in  1  instruction read request
- iaddr  in  ADDR_W  instruction address
- iwait  out  1  instruction access not yet complete
- iload  out  DATA_W  instruction read data
- dREN  in  1  data read request
- dWEN  in  1  data write request; dREN and dWEN are never both high
- daddr  in  ADDR_W  data address
- dstore  in  DATA_W  data write value
- dwait  out  1  data access not yet complete
- dload  out  DATA_W  data read data
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  ADDR_W  RAM address
- ramstore  out  DATA_W  RAM write data
- ramload  in  DATA_W  RAM read data
- ramstate  in  ramstate_t  RAM status: FREE, BUSY, ACCESS, ERROR

## Operation
FSM states are IDLE, IGRANT, DGRANT, COOL.

IDLE:
- dREN|dWEN → DGRANT.
- Else iREN → IGRANT.
- Else stay in IDLE.
- Guard build: if both requesters are pending and streak==STARVE_MAX → IGRANT.

IGRANT:
- ramREN=1, ramaddr=iaddr.
- ramstate==ACCESS → iload=ramload, iwait=0, next state COOL.

DGRANT:
- ramREN=dREN, ramWEN=dWEN, ramaddr=daddr, ramstore=dstore.
- ramstate==ACCESS → dload=ramload, dwait=0, next state COOL.

COOL:
- Lasts one cycle, with all RAM enables 0.
- Lets the requester drop or update its request before re-arbitration → IDLE.

Other rules:
- Request withdrawn while granted (iREN=0 in IGRANT; dREN=dWEN=0 in DGRANT) → abort to IDLE next cycle. RAM enables drop combinationally in that cycle.
- ramstate ERROR or BUSY → hold the grant and keep the wait asserted; the access is retried until ACCESS.
- Wait outputs are combinational:
  - iwait = iREN & ~(state==IGRANT & ramstate==ACCESS)
  - dwait = (dREN|dWEN) & ~(state==DGRANT & ramstate==ACCESS)
- Requester asserting a request while the other requester is granted → its wait stays high; there is no preemption.
- Load outputs are 0 except in their completion cycle.
- Streak counter is $clog2(STARVE_MAX+1) bits and saturating:
  - +1 on each IDLE→DGRANT decision taken while iREN=1.
  - Cleared on IDLE→IGRANT, or on an IDLE→DGRANT decision taken with iREN=0.

## Timing
- Reset (async, immediate):
  - state=IDLE, streak=0.
  - ramREN=ramWEN=0, ramaddr=ramstore=0, iload=dload=0.
  - Waits follow their combinational equations.
- Minimum access latency: request seen in IDLE at cycle 0; grant in cycle 1; with ramstate==ACCESS in cycle 1, wait drops in cycle 1.
- Back-to-back accesses from one requester occur at most every 3 cycles (IDLE, GRANT, COOL).
- Simultaneous iREN and dREN in IDLE → data is granted, unless the guard fires.
- nRST asserted mid-grant aborts the grant: enables drop asynchronously and no completion is reported.

## Configuration
- ARB_STARVE_GUARD_EN defined: the streak counter and STARVE_MAX override are compiled in.
- Undefined: pure fixed data priority; no counter flops; STARVE_MAX is ignored.

## Structure
- cpu_types_pkg gains the typedef `arb_state_t` (IDLE, IGRANT, DGRANT, COOL).
- cpu_types_pkg already provides `ramstate_t` and the word/address types.
- No sub-module: the FSM, counter and output mux live in `mem_arbiter`.
- New interface `mem_arbiter_if` with modports `arb` and `tb`.

## Test plan
- Single I read: iREN=1, iaddr=0x40, ACCESS on cycle 1 with ramload=0xDEADBEEF → iload=0xDEADBEEF and iwait=0 in cycle 1, ramREN=0 in cycle 2 (COOL).
- Tie: iREN=dREN=1 in IDLE → DGRANT with ramaddr=daddr; iwait stays 1 until the data access completes, then IGRANT follows after COOL.
- Write: dWEN=1, daddr=0x100, dstore=0x12345678, BUSY×3 then ACCESS → ramWEN=1 for 4 cycles; dwait=0 only in the 4th.
- Starvation (guard on, STARVE_MAX=4): dREN held high continuously, iREN=1 → 4 data grants, then the 5th grant goes to I; guard off → I never granted.
- Withdrawal: dREN dropped during BUSY in DGRANT → ramREN=0 that cycle, state IDLE next cycle, dload=0.
- Reset mid-grant: nRST low during IGRANT → ramREN=0 immediately; after release, state=IDLE and streak=0.
